// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response compactor: FSM states and the
// default MISR configuration used for the s298 core.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COMPACT,
    ST_DONE
  } state_e;

  // x^16 + x^12 + x^5 + 1, bit i set means tap i
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  // s298 primary outputs {G133,G132,G118,G117,G67,G66}
  localparam int S298_RESP_W = 6;

endpackage

// File: rtl/misr_core.sv
// Parameterised multiple-input signature register. Reusable for any core
// whose response width does not exceed the signature width.
module misr_core #(
  parameter int               SIG_W = 16,
  parameter int               IN_W  = 6,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // Next signature: reload seed, fold in one response word, or hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    sig_d = sig_q;
    if (load_seed) begin
      sig_d = SEED;
    end else if (shift_en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ SIG_W'(din);
    end
  end

  // Signature register; reset puts it straight back to the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_misr_compactor.sv
// Response compactor for the s298 BIST chain: after a start request it
// skips a warm-up window (the core flops have no reset), folds n_cycles
// response words into a MISR and reports the golden comparison.
module bist_misr_compactor
  import bist_pkg::*;
#(
  parameter int               SIG_W  = 16,
  parameter int               RESP_W = S298_RESP_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               WARMUP = 14,
  parameter int               CNT_W  = 16
) (
  input  logic              CK,
  input  logic              RSTn,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_cycles,
  input  logic [SIG_W-1:0]  golden,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  // Counter value on the last warm-up edge; unused when WARMUP is 0.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ncyc_q, ncyc_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             accept;
  logic             shift_en;
  logic [SIG_W-1:0] sig;

  // A new run is only taken when no run is in progress.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State, counter and captured run parameters.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ncyc_q   <= '0;
      golden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ncyc_q   <= ncyc_d;
      golden_q <= golden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  // Next-state logic: warm-up counts WARMUP edges, compaction counts n samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ncyc_d   = ncyc_q;
    golden_d = golden_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          ncyc_d   = n_cycles;
          golden_d = golden;
          cnt_d    = '0;
          if (WARMUP > 0)         state_d = ST_WARMUP;
          else if (n_cycles != 0) state_d = ST_COMPACT;
          else                    state_d = ST_DONE;
        end
      end
      ST_WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = (ncyc_q != 0) ? ST_COMPACT : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_COMPACT: begin
        if (cnt_q == ncyc_q - 1'b1) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output logic: busy follows the next state, done/pass are resolved one
  // edge after entering DONE so the final signature has settled.
  always_comb begin
    shift_en = (state_q == ST_COMPACT);
    busy_d   = (state_d == ST_WARMUP) || (state_d == ST_COMPACT);
    done_d   = !accept && (state_q == ST_DONE);
    pass_d   = pass_q;
    if (accept)                                pass_d = 1'b0;
    else if ((state_q == ST_DONE) && !done_q)  pass_d = (sig == golden_q);
  end

  misr_core #(
    .SIG_W (SIG_W),
    .IN_W  (RESP_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (CK),
    .rst_n     (RSTn),
    .load_seed (accept),
    .shift_en  (shift_en),
    .din       (resp),
    .sig       (sig)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Directed bench for bist_misr_compactor: one instance without warm-up and
// one with the 14-cycle warm-up, expected results queued at each start.
module tb_bist_misr_compactor;

  logic        CK = 1'b0;
  logic        RSTn;

  logic        start0, start1;
  logic [15:0] ncyc0, ncyc1, golden0, golden1;
  logic [5:0]  resp0, resp1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] sig0, sig1;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 CK = ~CK;

  bist_misr_compactor #(.WARMUP(0)) u_dut0 (
    .CK(CK), .RSTn(RSTn), .start(start0), .n_cycles(ncyc0), .golden(golden0),
    .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  bist_misr_compactor #(.WARMUP(14)) u_dut14 (
    .CK(CK), .RSTn(RSTn), .start(start1), .n_cycles(ncyc1), .golden(golden1),
    .resp(resp1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input logic s, input logic [15:0] n, input logic [15:0] g);
    if (sel) begin start1 = s; ncyc1 = n; golden1 = g; end
    else     begin start0 = s; ncyc0 = n; golden0 = g; end
  endtask

  task automatic set_start(input bit sel, input logic s);
    if (sel) start1 = s; else start0 = s;
  endtask

  task automatic set_resp(input bit sel, input logic [5:0] r);
    if (sel) resp1 = r; else resp0 = r;
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? done1 : done0;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic get_pass(input bit sel);
    return sel ? pass1 : pass0;
  endfunction
  function automatic logic [15:0] get_sig(input bit sel);
    return sel ? sig1 : sig0;
  endfunction

  // One run: queue the expectation, pulse start, then step edge by edge
  // (driving resp per edge) until done rises or the budget runs out.
  task automatic run(input bit sel, input int w, input int n, input logic [15:0] g,
                     input logic [5:0] warm, input logic [5:0] comp,
                     input logic [15:0] exp_sig, input logic exp_pass,
                     input int mid_at, input logic [15:0] mid_sig, input int pulse_at);
    int   edges;
    bit   got;
    exp_t e;
    sb.push_back('{sig: exp_sig, pass: exp_pass, lat: w + n + 1});
    @(negedge CK);
    drive(sel, 1'b1, 16'(n), g);
    set_resp(sel, comp);
    @(posedge CK);
    edges = 0;
    got   = 0;
    while (!got && edges <= 400) begin
      @(negedge CK);
      set_start(sel, 1'b0);
      if (edges == 0) begin
        check("done_low_after_start", {31'd0, get_done(sel)}, 32'd0);
        check("busy_after_start", {31'd0, get_busy(sel)}, {31'd0, (w + n) > 0});
      end
      if (edges == pulse_at) begin
        check("busy_at_ignored_start", {31'd0, get_busy(sel)}, 32'd1);
        drive(sel, 1'b1, 16'd5, 16'h1234);
      end
      if (edges == mid_at) check("mid_signature", {16'd0, get_sig(sel)}, {16'd0, mid_sig});
      if (get_done(sel)) begin
        got = 1;
      end else begin
        set_resp(sel, (edges < w) ? (edges[0] ? 6'h00 : warm) : comp);
        @(posedge CK);
        edges++;
      end
    end
    set_start(sel, 1'b0);
    e = sb.pop_front();
    check("done_latency", edges, e.lat);
    check("final_signature", {16'd0, get_sig(sel)}, {16'd0, e.sig});
    check("pass_flag", {31'd0, get_pass(sel)}, {31'd0, e.pass});
    check("busy_in_done", {31'd0, get_busy(sel)}, 32'd0);
  endtask

  initial begin
    RSTn = 1'b0;
    drive(0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 16'd0, 16'd0);
    resp0 = '0;
    resp1 = '0;
    #12;
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_pass", {31'd0, pass0}, 32'd0);
    check("rst_sig", {16'd0, sig0}, 32'd0);
    check("rst_sig_w14", {16'd0, sig1}, 32'd0);
    @(negedge CK);
    RSTn = 1'b1;

    // n=2, resp=01: 0001 then 0003, golden matches, done 3 edges after start
    run(0, 0, 2, 16'h0003, 6'h00, 6'h01, 16'h0003, 1'b1, -1, 16'h0, -1);
    repeat (3) @(negedge CK);
    check("done_held", {31'd0, done0}, 32'd1);
    check("pass_held", {31'd0, pass0}, 32'd1);
    check("sig_held", {16'd0, sig0}, 32'h0003);

    // restart from DONE: n=1, resp=3F, golden 0 -> fail
    run(0, 0, 1, 16'h0000, 6'h00, 6'h3F, 16'h003F, 1'b0, -1, 16'h0, -1);

    // n=17, resp=01: FFFF after 16 samples, feedback gives EFDE after 17
    run(0, 0, 17, 16'hEFDE, 6'h00, 6'h01, 16'hEFDE, 1'b1, 16, 16'hFFFF, -1);

    // warm-up instance: toggling 3F ignored during warm-up, then 01 twice
    run(1, 14, 2, 16'h0003, 6'h3F, 6'h01, 16'h0003, 1'b1, -1, 16'h0, -1);

    // zero-length run with a start pulsed while busy (ignored)
    run(1, 14, 0, 16'h0000, 6'h3F, 6'h3F, 16'h0000, 1'b1, -1, 16'h0, 3);
    repeat (8) @(negedge CK);
    check("ignored_start_no_rerun", {31'd0, busy1}, 32'd0);
    check("ignored_start_done_held", {31'd0, done1}, 32'd1);

    // reset in the middle of a compaction run
    @(negedge CK);
    drive(0, 1'b1, 16'd100, 16'h0000);
    resp0 = 6'h01;
    @(negedge CK);
    start0 = 1'b0;
    repeat (5) @(negedge CK);
    check("busy_mid_run", {31'd0, busy0}, 32'd1);
    RSTn = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy0}, 32'd0);
    check("async_rst_done", {31'd0, done0}, 32'd0);
    check("async_rst_pass", {31'd0, pass0}, 32'd0);
    check("async_rst_sig", {16'd0, sig0}, 32'h0000);
    check("async_rst_done_w14", {31'd0, done1}, 32'd0);
    #1;
    RSTn = 1'b1;

    // fresh run from IDLE after the abort
    run(0, 0, 1, 16'h003F, 6'h00, 6'h3F, 16'h003F, 1'b1, -1, 16'h0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
